// File: rtl/cache_pkg.sv
// Shared types and default geometry for the set-associative instruction cache.
package cache_pkg;

  localparam int unsigned DefByteOffsetBits = 4;
  localparam int unsigned DefIndexBits      = 6;
  localparam int unsigned DefTagBits        = 22;
  localparam int unsigned DefNrWays         = 2;

  localparam int unsigned NrWordsPerLine = (2 ** DefByteOffsetBits) / 4;
  localparam int unsigned LineSize       = 32 * NrWordsPerLine;
  localparam int unsigned NrSets         = 2 ** DefIndexBits;

  typedef logic [LineSize-1:0] line_t;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } cache_state_e;

  // Width of a pointer selecting one of n items; never narrower than one bit.
  function automatic int unsigned ptr_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: valid/tag/data arrays with an asynchronous read by index
// and a single synchronous write port.
module cache_way
  import cache_pkg::*;
#(
  parameter int unsigned IndexBits = 6,
  parameter int unsigned TagBits   = 22,
  parameter int unsigned LineBits  = 128
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [IndexBits-1:0] i_rd_index,
  output logic                 o_valid,
  output logic [TagBits-1:0]   o_tag,
  output logic [LineBits-1:0]  o_line,
  input  logic                 i_we,
  input  logic [IndexBits-1:0] i_wr_index,
  input  logic [TagBits-1:0]   i_wr_tag,
  input  logic [LineBits-1:0]  i_wr_line
);

  localparam int unsigned NrEntries = 2 ** IndexBits;

  logic [NrEntries-1:0] r_valid;
  logic [TagBits-1:0]   r_tag  [NrEntries];
  logic [LineBits-1:0]  r_line [NrEntries];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge, regardless of block ordering.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits
  // alone gate a hit, so the arrays can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_line[i_wr_index] <= i_wr_line;
    end
  end

  assign o_valid = r_valid[i_rd_index];
  assign o_tag   = r_tag[i_rd_index];
  assign o_line  = r_line[i_rd_index];

endmodule

// File: rtl/set_assoc_cache.sv
// Read-only N-way set-associative fetch cache with per-set round-robin
// replacement. Define CACHE_STATS_EN to add hit/miss counter ports.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ByteOffsetBits = DefByteOffsetBits,
  parameter int unsigned IndexBits      = DefIndexBits,
  parameter int unsigned TagBits        = DefTagBits,
  parameter int unsigned NrWays         = DefNrWays
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] addr_i,
  input  logic        read_en_i,
  output logic        read_valid_o,
  output logic [31:0] read_word_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_read_en_o,
  input  logic        mem_read_valid_i,
  input  logic [32*((2**ByteOffsetBits)/4)-1:0] mem_read_data_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int unsigned WordsPerLine = (2 ** ByteOffsetBits) / 4;
  localparam int unsigned LineBits     = 32 * WordsPerLine;
  localparam int unsigned SetCount     = 2 ** IndexBits;
  localparam int unsigned WayBits      = ptr_bits(NrWays);
  localparam int unsigned WordBits     = ptr_bits(WordsPerLine);

  if (ByteOffsetBits + IndexBits + TagBits != 32) begin : g_bad_geometry
    $error("set_assoc_cache: ByteOffsetBits+IndexBits+TagBits must equal 32");
  end
  if (NrWays < 1 || (NrWays & (NrWays - 1)) != 0) begin : g_bad_ways
    $error("set_assoc_cache: NrWays must be a power of two >= 1");
  end

  cache_state_e r_state, w_state_nxt;

  logic [IndexBits-1:0] w_index, r_index, w_rd_index;
  logic [TagBits-1:0]   w_tag, r_tag;
  logic [WordBits-1:0]  w_word_sel, r_word;
  logic                 w_unused_addr;

  logic                w_way_valid [NrWays];
  logic [TagBits-1:0]  w_way_tag   [NrWays];
  logic [LineBits-1:0] w_way_line  [NrWays];
  logic [NrWays-1:0]   w_way_we;

  logic                w_hit;
  logic [WayBits-1:0]  w_hit_way;
  logic [31:0]         w_hit_word;
  logic [31:0]         w_fwd_word;
  logic                w_victim_found;
  logic [WayBits-1:0]  w_victim;
  logic                w_fill;
  logic [WayBits-1:0]  r_rr [SetCount];

  logic        r_read_valid, w_read_valid_nxt;
  logic [31:0] r_read_word,  w_read_word_nxt;
  logic        r_mem_en,     w_mem_en_nxt;
  logic [31:0] r_mem_addr,   w_mem_addr_nxt;
  logic        w_latch_req;

  assign w_index       = addr_i[ByteOffsetBits +: IndexBits];
  assign w_tag         = addr_i[ByteOffsetBits+IndexBits +: TagBits];
  assign w_word_sel    = WordBits'((addr_i >> 2) & 32'(WordsPerLine - 1));
  assign w_unused_addr = &{1'b0, addr_i[1:0]};

  // While a miss is outstanding the ways look at the latched set, so the
  // victim choice cannot be disturbed by a changing addr_i.
  assign w_rd_index = (r_state == MISS) ? r_index : w_index;
  assign w_fill     = (r_state == MISS) && mem_read_valid_i;

  for (genvar g = 0; g < NrWays; g++) begin : g_way
    assign w_way_we[g] = w_fill && (w_victim == WayBits'(g));

    cache_way #(
      .IndexBits (IndexBits),
      .TagBits   (TagBits),
      .LineBits  (LineBits)
    ) u_way (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .i_rd_index (w_rd_index),
      .o_valid    (w_way_valid[g]),
      .o_tag      (w_way_tag[g]),
      .o_line     (w_way_line[g]),
      .i_we       (w_way_we[g]),
      .i_wr_index (r_index),
      .i_wr_tag   (r_tag),
      .i_wr_line  (mem_read_data_i)
    );
  end

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < NrWays; w++) begin
      if (!w_hit && w_way_valid[w] && (w_way_tag[w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WayBits'(w);
      end
    end
  end

  assign w_hit_word = w_way_line[w_hit_way][{w_word_sel, 5'd0} +: 32];
  assign w_fwd_word = mem_read_data_i[{r_word, 5'd0} +: 32];

  // Fill the lowest invalid way first; only a full set consults rr_ptr.
  always_comb begin
    w_victim_found = 1'b0;
    w_victim       = r_rr[r_index];
    for (int w = 0; w < NrWays; w++) begin
      if (!w_victim_found && !w_way_valid[w]) begin
        w_victim_found = 1'b1;
        w_victim       = WayBits'(w);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (read_en_i && !w_hit) w_state_nxt = MISS;
      MISS:    if (mem_read_valid_i)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_read_valid_nxt = 1'b0;
    w_read_word_nxt  = r_read_word;
    w_mem_en_nxt     = r_mem_en;
    w_mem_addr_nxt   = r_mem_addr;
    w_latch_req      = 1'b0;
    case (r_state)
      IDLE: begin
        if (read_en_i) begin
          if (w_hit) begin
            w_read_valid_nxt = 1'b1;
            w_read_word_nxt  = w_hit_word;
          end else begin
            w_latch_req    = 1'b1;
            w_mem_en_nxt   = 1'b1;
            w_mem_addr_nxt = {w_tag, w_index, {ByteOffsetBits{1'b0}}};
          end
        end
      end
      MISS: begin
        if (mem_read_valid_i) begin
          w_mem_en_nxt = 1'b0;
          if (read_en_i) begin
            w_read_valid_nxt = 1'b1;
            w_read_word_nxt  = w_fwd_word;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_read_valid <= 1'b0;
      r_read_word  <= '0;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_index      <= '0;
      r_tag        <= '0;
      r_word       <= '0;
      for (int s = 0; s < SetCount; s++) r_rr[s] <= '0;
    end else begin
      r_read_valid <= w_read_valid_nxt;
      r_read_word  <= w_read_word_nxt;
      r_mem_en     <= w_mem_en_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      if (w_latch_req) begin
        r_index <= w_index;
        r_tag   <= w_tag;
        r_word  <= w_word_sel;
      end
      if (w_fill) begin
        r_rr[r_index] <= WayBits'((32'(w_victim) + 32'd1) % NrWays);
      end
    end
  end

  assign read_valid_o  = r_read_valid;
  assign read_word_o   = r_read_word;
  assign mem_read_en_o = r_mem_en;
  assign mem_addr_o    = r_mem_addr;

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == IDLE && read_en_i) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Self-checking bench for set_assoc_cache: directed scenarios followed by
// randomized traffic, checked against a per-set way model.
module tb_set_assoc_cache;
  import cache_pkg::*;

  localparam int NWays = 2;
  localparam int NSets = 64;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        read_en_i = 1'b0;
  logic        read_valid_o;
  logic [31:0] read_word_o;
  logic [31:0] mem_addr_o;
  logic        mem_read_en_o;
  logic        mem_read_valid_i = 1'b0;
  line_t       mem_read_data_i = '0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  set_assoc_cache #(
    .ByteOffsetBits (4),
    .IndexBits      (6),
    .TagBits        (22),
    .NrWays         (NWays)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .addr_i           (addr_i),
    .read_en_i        (read_en_i),
    .read_valid_o     (read_valid_o),
    .read_word_o      (read_word_o),
    .mem_addr_o       (mem_addr_o),
    .mem_read_en_o    (mem_read_en_o),
    .mem_read_valid_i (mem_read_valid_i),
    .mem_read_data_i  (mem_read_data_i)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt_o        (hit_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
`endif
  );

  // Reference model: each set is a small table of ways plus a replacement pointer.
  bit          m_valid [NSets][NWays];
  logic [21:0] m_tag   [NSets][NWays];
  line_t       m_line  [NSets][NWays];
  int          m_rr    [NSets];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] last_word = '0;
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic m_clear();
    for (int s = 0; s < NSets; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NWays; w++) m_valid[s][w] = 1'b0;
    end
    last_word  = '0;
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  function automatic int m_lookup(input logic [31:0] a);
    int s;
    s = int'(a[9:4]);
    for (int w = 0; w < NWays; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[31:10]) return w;
    return -1;
  endfunction

  task automatic m_install(input logic [31:0] a, input line_t ln);
    int s;
    int v;
    s = int'(a[9:4]);
    v = -1;
    for (int w = 0; w < NWays; w++) begin
      if (v < 0 && !m_valid[s][w]) v = w;
    end
    if (v < 0) v = m_rr[s];
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = a[31:10];
    m_line[s][v]  = ln;
    m_rr[s]       = (v + 1) % NWays;
  endtask

  // One request from an idle cycle to its completion; misses are filled
  // after `delay` wait cycles, optionally with the request withdrawn.
  task automatic read_op(input logic [31:0] a, input line_t fill, input bit drop, input int delay);
    int way;
    int s;
    int wd;
    logic [31:0] line_addr;
    s = int'(a[9:4]);
    wd = int'(a[3:2]);
    line_addr = {a[31:4], 4'h0};
    way = m_lookup(a);
    addr_i = a;
    read_en_i = 1'b1;
    tick();
    if (way >= 0) begin
      exp_hits++;
      last_word = m_line[s][way][32*wd +: 32];
      check("hit_valid", 32'(read_valid_o), 32'd1);
      check("hit_word", read_word_o, last_word);
      check("hit_no_mem", 32'(mem_read_en_o), 32'd0);
      read_en_i = 1'b0;
    end else begin
      exp_misses++;
      check("miss_valid", 32'(read_valid_o), 32'd0);
      check("miss_mem_en", 32'(mem_read_en_o), 32'd1);
      check("miss_mem_addr", mem_addr_o, line_addr);
      if (drop) read_en_i = 1'b0;
      for (int i = 0; i < delay; i++) begin
        addr_i = $urandom;
        tick();
        check("wait_mem_en", 32'(mem_read_en_o), 32'd1);
        check("wait_mem_addr", mem_addr_o, line_addr);
        check("wait_valid", 32'(read_valid_o), 32'd0);
      end
      mem_read_valid_i = 1'b1;
      mem_read_data_i = fill;
      tick();
      mem_read_valid_i = 1'b0;
      read_en_i = 1'b0;
      addr_i = a;
      check("fill_mem_en", 32'(mem_read_en_o), 32'd0);
      if (drop) begin
        check("drop_valid", 32'(read_valid_o), 32'd0);
        check("drop_word_held", read_word_o, last_word);
      end else begin
        last_word = fill[32*wd +: 32];
        check("fill_valid", 32'(read_valid_o), 32'd1);
        check("fill_word", read_word_o, last_word);
      end
      m_install(a, fill);
    end
  endtask

  task automatic idle_op();
    read_en_i = 1'b0;
    addr_i = $urandom;
    mem_read_valid_i = ($urandom_range(0, 3) == 0);
    mem_read_data_i = {$urandom, $urandom, $urandom, $urandom};
    tick();
    mem_read_valid_i = 1'b0;
    check("idle_valid", 32'(read_valid_o), 32'd0);
    check("idle_word_held", read_word_o, last_word);
    check("idle_mem_en", 32'(mem_read_en_o), 32'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
    check({tag, "_hits"}, hit_cnt_o, exp_hits);
    check({tag, "_misses"}, miss_cnt_o, exp_misses);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    line_t fill_a;
    logic [31:0] a;
    m_clear();
    fill_a = 128'hDEADBEEF_DEADBEEF_FEFEFEFE_BEEFDEAD;

    repeat (2) tick();
    check("rst_valid", 32'(read_valid_o), 32'd0);
    check("rst_word", read_word_o, 32'd0);
    check("rst_mem_en", 32'(mem_read_en_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    rstn_i = 1'b1;
    tick();

    read_op(32'h414, fill_a, 1'b0, 2);
    read_op(32'h418, '0, 1'b0, 0);
    read_op(32'h814, {4{32'hFFFF_FFFF}}, 1'b0, 1);
    read_op(32'h414, '0, 1'b0, 0);
    check_stats("stats_early");
    idle_op();

    read_op(32'hC14, {4{32'hAAAA_AAAA}}, 1'b0, 0);
    read_op(32'h814, '0, 1'b0, 0);
    read_op(32'h414, fill_a, 1'b0, 1);

    read_op(32'h440, {4{32'hEEEE_EEEE}}, 1'b1, 2);
    read_op(32'h44C, '0, 1'b0, 0);
    check_stats("stats_mid");

    // Reset in the middle of an outstanding miss.
    addr_i = 32'h424;
    read_en_i = 1'b1;
    tick();
    check("rst_miss_mem_en_before", 32'(mem_read_en_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    check("rst_miss_mem_en", 32'(mem_read_en_o), 32'd0);
    check("rst_miss_mem_addr", mem_addr_o, 32'd0);
    m_clear();
    read_en_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    mem_read_valid_i = 1'b1;
    mem_read_data_i = {4{32'h1234_5678}};
    tick();
    mem_read_valid_i = 1'b0;
    check("late_fill_valid", 32'(read_valid_o), 32'd0);
    check("late_fill_mem_en", 32'(mem_read_en_o), 32'd0);
    read_op(32'h414, {4{32'h5555_5555}}, 1'b0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_op();
      end else begin
        a = {22'($urandom_range(1, 5)), 6'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'b00};
        read_op(a, {$urandom, $urandom, $urandom, $urandom},
                ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
      end
    end
    check_stats("stats_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
